sc_io_input_port: RTL

- Memory-mapped input peripheral for the single-cycle CPU with IO; it handles the input direction, complementing the CPU's output port (out_port0).
- Synchronizes and debounces board switches and active-low push keys.
- Latches key-press events as sticky, clear-on-read flags.
- Presents all state as read-only 32-bit words on the data-memory address/read path, muxed into the CPU memout alongside data memory.

---
 rtl/sc_io_input_port.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sc_io_input_port.sv
// sc_io_input_port: synced, debounced switch/key input block on the CPU load path.
// Build option RELEASE_EVENT_EN adds sticky key-release flags at KEY_EVENT[KEY_WIDTH+15:16].
module sc_io_input_port #(
  parameter int          SW_WIDTH        = 10,
  parameter int          KEY_WIDTH       = 4,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_00C0
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [31:0]          addr,
  input  logic                 re,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic [KEY_WIDTH-1:0] key_n,
  output logic                 hit,
  output logic [31:0]          dataout,
  output logic                 event_pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0]  sw_s1_q, sw_s1_d;
  logic [SW_WIDTH-1:0]  sw_s2_q, sw_s2_d;
  logic [KEY_WIDTH-1:0] key_s1_q, key_s1_d;
  logic [KEY_WIDTH-1:0] key_s2_q, key_s2_d;
  logic [SW_WIDTH-1:0]  stable_sw_q, stable_sw_d;
  logic [CW-1:0]        sw_cnt_q, sw_cnt_d;
  logic [KEY_WIDTH-1:0] stable_key_q, stable_key_d;
  logic [KEY_WIDTH-1:0][CW-1:0] key_cnt_q, key_cnt_d;
  logic [KEY_WIDTH-1:0] key_event_q, key_event_d;
  logic [7:0]           press_cnt_q, press_cnt_d;
  logic                 event_pending_q, event_pending_d;
`ifdef RELEASE_EVENT_EN
  logic [KEY_WIDTH-1:0] rel_event_q, rel_event_d;
  logic [KEY_WIDTH-1:0] key_fall;
`endif

  logic [KEY_WIDTH-1:0] key_sync;
  logic [KEY_WIDTH-1:0] key_rise;
  logic [7:0]           rise_cnt;
  logic                 rd_clr;
  logic                 unused_addr;

  assign hit         = addr[31:4] == BASE_ADDR[31:4];
  assign key_sync    = ~key_s2_q;
  assign rd_clr      = re & hit & (addr[3:2] == 2'd2);
  assign unused_addr = ^addr[1:0];

  assign event_pending = event_pending_q;

  always_comb begin
    sw_s1_d     = sw;
    sw_s2_d     = sw_s1_q;
    key_s1_d    = key_n;
    key_s2_d    = key_s1_q;
    stable_sw_d = stable_sw_q;
    sw_cnt_d    = '0;
    if (sw_s2_q != stable_sw_q) begin
      if (sw_cnt_q == CNT_MAX) stable_sw_d = sw_s2_q;
      else sw_cnt_d = sw_cnt_q + 1'b1;
    end
  end

  // each key has its own counter so one bouncing key cannot stall another
  always_comb begin
    stable_key_d = stable_key_q;
    key_cnt_d    = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (key_sync[i] != stable_key_q[i]) begin
        if (key_cnt_q[i] == CNT_MAX) stable_key_d[i] = key_sync[i];
        else key_cnt_d[i] = key_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    key_rise = stable_key_d & ~stable_key_q;
    rise_cnt = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      rise_cnt = rise_cnt + {7'd0, key_rise[i]};
    end
    press_cnt_d     = press_cnt_q + rise_cnt;
    key_event_d     = (rd_clr ? '0 : key_event_q) | key_rise;
    event_pending_d = |key_event_d;
`ifdef RELEASE_EVENT_EN
    key_fall        = ~stable_key_d & stable_key_q;
    rel_event_d     = (rd_clr ? '0 : rel_event_q) | key_fall;
    event_pending_d = |{key_event_d, rel_event_d};
`endif
  end

  always_comb begin
    dataout = '0;
    if (hit) begin
      unique case (addr[3:2])
        2'd0: dataout[SW_WIDTH-1:0]  = stable_sw_q;
        2'd1: dataout[KEY_WIDTH-1:0] = stable_key_q;
        2'd2: begin
          dataout[KEY_WIDTH-1:0] = key_event_q;
`ifdef RELEASE_EVENT_EN
          dataout[KEY_WIDTH+15:16] = rel_event_q;
`endif
        end
        2'd3: begin
          dataout[23:16] = press_cnt_q;
          dataout[0]     = event_pending_q;
        end
        default: dataout = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q         <= '0;
      sw_s2_q         <= '0;
      key_s1_q        <= '1;
      key_s2_q        <= '1;
      stable_sw_q     <= '0;
      sw_cnt_q        <= '0;
      stable_key_q    <= '0;
      key_cnt_q       <= '0;
      key_event_q     <= '0;
      press_cnt_q     <= '0;
      event_pending_q <= 1'b0;
`ifdef RELEASE_EVENT_EN
      rel_event_q     <= '0;
`endif
    end else begin
      sw_s1_q         <= sw_s1_d;
      sw_s2_q         <= sw_s2_d;
      key_s1_q        <= key_s1_d;
      key_s2_q        <= key_s2_d;
      stable_sw_q     <= stable_sw_d;
      sw_cnt_q        <= sw_cnt_d;
      stable_key_q    <= stable_key_d;
      key_cnt_q       <= key_cnt_d;
      key_event_q     <= key_event_d;
      press_cnt_q     <= press_cnt_d;
      event_pending_q <= event_pending_d;
`ifdef RELEASE_EVENT_EN
      rel_event_q     <= rel_event_d;
`endif
    end
  end

endmodule
